// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle MIPS main control FSM with a memory-ready
// handshake and timeout, R/LW/SW/BEQ/ADDI/ORI/J sequencing, an illegal-opcode
// trap and a sticky ERROR state.
// Optional feature: define MC_BNE_EN to decode BNE (opcode 000101); otherwise
// BNE traps as an illegal opcode and branch_ne is tied low.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   op[5:0]          opcode instr[31:26], valid from DECODE onward
//   mem_ready        memory completes current access this cycle
//   memread, iord, irwrite, memwrite, memtoreg, regwrite, regdst, alusrca,
//   pcwrite, branch, branch_ne, alusrcb[1:0], aluop[1:0], pcsrc[1:0], zeroext
//                    datapath controls decoded from the current state
//   instr_done       pulse on the final cycle of each instruction
//   err, err_code    sticky error flag and cause (01 illegal op, 10 timeout)
//   state_o[3:0]     current state, debug
module mc_control_fsm #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       memread,
  output logic       iord,
  output logic       irwrite,
  output logic       memwrite,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       regdst,
  output logic       alusrca,
  output logic       pcwrite,
  output logic       branch,
  output logic       branch_ne,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       zeroext,
  output logic       instr_done,
  output logic       err,
  output logic [1:0] err_code,
  output logic [3:0] state_o
);

  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_REXEC  = 4'd6,  S_RWB    = 4'd7,
    S_BEQ    = 4'd8,  S_ADDIEX = 4'd9,  S_IWB    = 4'd10, S_JUMP   = 4'd11,
    S_ORIEX  = 4'd12, S_BNE    = 4'd13, S_ERROR  = 4'd15
  } state_t;

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [1:0]      ec_q, ec_d;
  logic            wait_c;

  // State, timeout counter and error cause registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      ec_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ec_q    <= ec_d;
    end
  end

  // Next-state logic; the counter is zero on entry to every wait state
  // because any transition leaves cnt_d at its default of zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    ec_d    = ec_q;
    wait_c  = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE; else wait_c = 1'b1;
      S_DECODE: begin
        case (op)
          OP_RTYPE:     state_d = S_REXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BEQ;
`ifdef MC_BNE_EN
          OP_BNE:       state_d = S_BNE;
`endif
          OP_ADDI:      state_d = S_ADDIEX;
          OP_ORI:       state_d = S_ORIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d = S_ERROR;
            ec_d    = 2'b01;
          end
        endcase
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB; else wait_c = 1'b1;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH; else wait_c = 1'b1;
      S_REXEC:  state_d = S_RWB;
      S_ADDIEX, S_ORIEX: state_d = S_IWB;
      S_MEMWB, S_RWB, S_IWB, S_BEQ, S_JUMP: state_d = S_FETCH;
`ifdef MC_BNE_EN
      S_BNE:    state_d = S_FETCH;
`endif
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_ERROR;
    endcase
    // A wait that has already lasted TIMEOUT cycles traps; mem_ready wins above
    if (wait_c) begin
      if (cnt_q >= TO_MAX) begin
        state_d = S_ERROR;
        ec_d    = 2'b10;
        cnt_d   = cnt_q;
      end else begin
        cnt_d = cnt_q + TO_W'(1);
      end
    end
  end

  // Moore control decode from the registered state
  always_comb begin
    memread    = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    memwrite   = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    alusrca    = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    pcsrc      = 2'b00;
    zeroext    = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR: begin alusrca = 1'b1; alusrcb = 2'b10; end
      S_MEMRD:  begin memread = 1'b1; iord = 1'b1; end
      S_MEMWB:  begin memtoreg = 1'b1; regwrite = 1'b1; instr_done = 1'b1; end
      S_MEMWR:  begin iord = 1'b1; memwrite = 1'b1; instr_done = mem_ready; end
      S_REXEC:  begin alusrca = 1'b1; aluop = 2'b10; end
      S_RWB:    begin regdst = 1'b1; regwrite = 1'b1; instr_done = 1'b1; end
      S_ADDIEX: begin alusrca = 1'b1; alusrcb = 2'b10; end
      S_ORIEX:  begin alusrca = 1'b1; alusrcb = 2'b10; aluop = 2'b11; zeroext = 1'b1; end
      S_IWB:    begin regwrite = 1'b1; instr_done = 1'b1; end
      S_BEQ: begin
        alusrca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; branch = 1'b1; instr_done = 1'b1;
      end
`ifdef MC_BNE_EN
      S_BNE: begin
        alusrca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; branch_ne = 1'b1; instr_done = 1'b1;
      end
`endif
      S_JUMP:   begin pcsrc = 2'b10; pcwrite = 1'b1; instr_done = 1'b1; end
      default:  ;
    endcase
  end

  assign err      = (state_q == S_ERROR);
  assign err_code = ec_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: scoreboard bench for mc_control_fsm. Stimulus pushes the
// expected state and control word for every driven cycle; a monitor on the
// falling edge pops and compares.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset, mem_ready;
  logic [5:0] op;
  logic       memread, iord, irwrite, memwrite, memtoreg, regwrite, regdst, alusrca;
  logic       pcwrite, branch, branch_ne, zeroext, instr_done, err;
  logic [1:0] alusrcb, aluop, pcsrc, err_code;
  logic [3:0] state_o;

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
                         MEMWB = 4'd4, MEMWR = 4'd5, REXEC = 4'd6, RWB = 4'd7,
                         BEQ = 4'd8, ADDIEX = 4'd9, IWB = 4'd10, JUMP = 4'd11,
                         ORIEX = 4'd12, BNE = 4'd13, ERR = 4'd15;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000,
                         OP_ORI = 6'b001101, OP_J = 6'b000010, OP_BAD = 6'b111111;

  typedef struct packed {
    logic [3:0]  st;
    logic [21:0] ctrl;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mc_control_fsm #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .memread(memread), .iord(iord), .irwrite(irwrite), .memwrite(memwrite),
    .memtoreg(memtoreg), .regwrite(regwrite), .regdst(regdst), .alusrca(alusrca),
    .pcwrite(pcwrite), .branch(branch), .branch_ne(branch_ne), .alusrcb(alusrcb),
    .aluop(aluop), .pcsrc(pcsrc), .zeroext(zeroext), .instr_done(instr_done),
    .err(err), .err_code(err_code), .state_o(state_o)
  );

  wire [21:0] act_ctrl = {memread, iord, irwrite, memwrite, memtoreg, regwrite, regdst,
                          alusrca, pcwrite, branch, branch_ne, alusrcb, aluop, pcsrc,
                          zeroext, instr_done, err, err_code};

  // Expected control word per state, taken from the control table
  function automatic logic [21:0] ctrl_of(input logic [3:0] st, input logic mr,
                                          input logic [1:0] ec);
    logic rd, io, irw, mw, m2r, rw, rdst, asa, pcw, br, brn, ze, dn, er;
    logic [1:0] asb, aop, psrc, ecx;
    {rd, io, irw, mw, m2r, rw, rdst, asa, pcw, br, brn, ze, dn, er} = '0;
    {asb, aop, psrc, ecx} = '0;
    case (st)
      FETCH:  begin rd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      DECODE: asb = 2'b11;
      MEMADR: begin asa = 1; asb = 2'b10; end
      MEMRD:  begin rd = 1; io = 1; end
      MEMWB:  begin m2r = 1; rw = 1; dn = 1; end
      MEMWR:  begin io = 1; mw = 1; dn = mr; end
      REXEC:  begin asa = 1; aop = 2'b10; end
      RWB:    begin rdst = 1; rw = 1; dn = 1; end
      ADDIEX: begin asa = 1; asb = 2'b10; end
      ORIEX:  begin asa = 1; asb = 2'b10; aop = 2'b11; ze = 1; end
      IWB:    begin rw = 1; dn = 1; end
      BEQ:    begin asa = 1; aop = 2'b01; psrc = 2'b01; br = 1; dn = 1; end
      BNE:    begin asa = 1; aop = 2'b01; psrc = 2'b01; brn = 1; dn = 1; end
      JUMP:   begin psrc = 2'b10; pcw = 1; dn = 1; end
      ERR:    begin er = 1; ecx = ec; end
      default: ;
    endcase
    return {rd, io, irw, mw, m2r, rw, rdst, asa, pcw, br, brn, asb, aop, psrc,
            ze, dn, er, ecx};
  endfunction

  // Drive one cycle and queue what the DUT must show during it
  task automatic step(input logic rst, input logic [5:0] o, input logic mr,
                      input logic [3:0] st, input logic [1:0] ec);
    exp_t e;
    reset     = rst;
    op        = o;
    mem_ready = mr;
    e.st      = st;
    e.ctrl    = ctrl_of(st, mr, ec);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      total++;
      if ({state_o, act_ctrl} !== {mon_e.st, mon_e.ctrl}) begin
        bad++;
        $display("FAIL cycle %0d state/ctrl: got %0d/%h want %0d/%h",
                 cyc, state_o, act_ctrl, mon_e.st, mon_e.ctrl);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; op = OP_R; mem_ready = 1'b0;
    @(posedge clk); #1;
    // Reset state (second reset cycle)
    step(1, OP_R, 0, FETCH, 0);
    // R-type, 4 cycles
    step(0, OP_R, 1, FETCH, 0);
    step(0, OP_R, 1, DECODE, 0);
    step(0, OP_R, 1, REXEC, 0);
    step(0, OP_R, 1, RWB, 0);
    // LW with three wait cycles in MEMRD
    step(0, OP_LW, 1, FETCH, 0);
    step(0, OP_LW, 1, DECODE, 0);
    step(0, OP_LW, 1, MEMADR, 0);
    for (int i = 0; i < 3; i++) step(0, OP_LW, 0, MEMRD, 0);
    step(0, OP_LW, 1, MEMRD, 0);
    step(0, OP_LW, 1, MEMWB, 0);
    // SW with two wait cycles in MEMWR
    step(0, OP_SW, 1, FETCH, 0);
    step(0, OP_SW, 1, DECODE, 0);
    step(0, OP_SW, 1, MEMADR, 0);
    for (int i = 0; i < 2; i++) step(0, OP_SW, 0, MEMWR, 0);
    step(0, OP_SW, 1, MEMWR, 0);
    // ADDI, ORI, BEQ, J
    step(0, OP_ADDI, 1, FETCH, 0);
    step(0, OP_ADDI, 1, DECODE, 0);
    step(0, OP_ADDI, 1, ADDIEX, 0);
    step(0, OP_ADDI, 1, IWB, 0);
    step(0, OP_ORI, 1, FETCH, 0);
    step(0, OP_ORI, 1, DECODE, 0);
    step(0, OP_ORI, 1, ORIEX, 0);
    step(0, OP_ORI, 1, IWB, 0);
    step(0, OP_BEQ, 1, FETCH, 0);
    step(0, OP_BEQ, 1, DECODE, 0);
    step(0, OP_BEQ, 1, BEQ, 0);
    step(0, OP_J, 1, FETCH, 0);
    step(0, OP_J, 1, DECODE, 0);
    step(0, OP_J, 1, JUMP, 0);
    // LW whose mem_ready arrives on the cycle the count reaches TIMEOUT
    step(0, OP_LW, 1, FETCH, 0);
    step(0, OP_LW, 1, DECODE, 0);
    step(0, OP_LW, 1, MEMADR, 0);
    for (int i = 0; i < 16; i++) step(0, OP_LW, 0, MEMRD, 0);
    step(0, OP_LW, 1, MEMRD, 0);
    step(0, OP_LW, 1, MEMWB, 0);
    // FETCH timeout: count 0..16 with no ready, then sticky ERROR code 10
    for (int i = 0; i < 17; i++) step(0, OP_R, 0, FETCH, 0);
    step(0, OP_R, 0, ERR, 2'b10);
    step(0, OP_R, 1, ERR, 2'b10);
    step(0, OP_R, 1, ERR, 2'b10);
    // Reset out of ERROR clears err and err_code
    step(1, OP_R, 0, ERR, 2'b10);
    step(0, OP_R, 0, FETCH, 0);
    // Illegal opcode
    step(0, OP_BAD, 1, FETCH, 0);
    step(0, OP_BAD, 1, DECODE, 0);
    step(0, OP_BAD, 1, ERR, 2'b01);
    step(0, OP_R, 1, ERR, 2'b01);
    step(1, OP_R, 1, ERR, 2'b01);
    step(0, OP_R, 0, FETCH, 0);
    // BNE: decoded only when the feature is built in
    step(0, OP_BNE, 1, FETCH, 0);
    step(0, OP_BNE, 1, DECODE, 0);
`ifdef MC_BNE_EN
    step(0, OP_BNE, 1, BNE, 0);
    step(0, OP_R, 0, FETCH, 0);
`else
    step(0, OP_BNE, 1, ERR, 2'b01);
    step(0, OP_R, 0, ERR, 2'b01);
`endif
    #10;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
